// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg: mode constants, FSM states and helpers shared by the shifter
package univ_shift_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  function automatic logic is_shift_mode(input logic [2:0] m);
    return m inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR};
  endfunction
endpackage

// File: rtl/univ_shift_step.sv
// univ_shift_step: one-step next-value function of the universal shift register
module univ_shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] Q,
  input  logic [2:0]       op,
  input  logic             DSL,
  input  logic             DSR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] q_next
);
  always_comb begin
    q_next = Q;
    case (op)
      MODE_SHR:  q_next = {DSR, Q[WIDTH-1:1]};
      MODE_SHL:  q_next = {Q[WIDTH-2:0], DSL};
      MODE_LOAD: q_next = D;
      MODE_ROR:  q_next = {Q[0], Q[WIDTH-1:1]};
      MODE_ROL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
      MODE_ASR:  q_next = {Q[WIDTH-1], Q[WIDTH-1:1]};
      MODE_CLR:  q_next = '0;
      default:   q_next = Q;
    endcase
  end
endmodule

// File: rtl/univ_shift_reg_n.sv
// univ_shift_reg_n: universal shift register with counted burst mode and BUSY/DONE handshake
module univ_shift_reg_n
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic             EN,
  input  logic [2:0]       S,
  input  logic             DSL,
  input  logic             DSR,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [CNT_W-1:0] N,
  output logic [WIDTH-1:0] Q,
  output logic             SOL,
  output logic             SOR,
  output logic             BUSY,
  output logic             DONE
);
  state_t state, st_d;
  logic [2:0] op, op_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] q_d, q_next;
  logic busy_d, done_d;
  assign SOL = Q[WIDTH-1];
  assign SOR = Q[0];
  univ_shift_step #(.WIDTH(WIDTH)) u_step (
    .Q(Q), .op(state == ST_RUN ? op : S), .DSL(DSL), .DSR(DSR), .D(D), .q_next(q_next)
  );
  always_comb begin
    q_d = Q;
    cnt_d = cnt;
    op_d = op;
    st_d = state;
    busy_d = BUSY;
    done_d = 1'b0;
    if (EN && state == ST_IDLE) begin
      if (START && is_shift_mode(S) && N != '0) begin
        op_d = S;
        cnt_d = N;
        st_d = ST_RUN;
        busy_d = 1'b1;
      end else if (START) done_d = 1'b1;
      else q_d = q_next;
    end else if (EN) begin
      q_d = q_next;
      cnt_d = cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        st_d = ST_IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      Q <= '0;
      cnt <= '0;
      op <= MODE_HOLD;
      state <= ST_IDLE;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      Q <= q_d;
      cnt <= cnt_d;
      op <= op_d;
      state <= st_d;
      BUSY <= busy_d;
      DONE <= done_d;
    end
  end
endmodule

// File: doc/univ_shift_reg_n.md
Name: univ_shift_reg_n

Overview:
- Parametrised universal shift register, WIDTH bits wide.
- Adds rotate, arithmetic shift and synchronous clear to the basic hold/shift/load set.
- Adds a counted burst mode: one START request performs N shifts with BUSY/DONE handshake.
- Used in the lab datapath as a serialiser/deserialiser and a multi-position shifter.

Parameters:
WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
CNT_W, 4, width of the burst count N; the maximum burst is 2^CNT_W-1 shifts.

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
CLRN  input  1  asynchronous, active-low reset (clear).
EN  input  1  clock enable; when low, Q, FSM and counter hold.
S  input  3  mode select (see Behaviour).
DSL  input  1  serial input shifted into Q[0] on a left shift.
DSR  input  1  serial input shifted into Q[WIDTH-1] on a right shift.
D  input  WIDTH  parallel load data.
START  input  1  burst request.
N  input  CNT_W  number of shifts in the burst.
Q  output  WIDTH  register contents.
SOL  output  1  equals Q[WIDTH-1] (combinational).
SOR  output  1  equals Q[0] (combinational).
BUSY  output  1  burst in progress.
DONE  output  1  one-cycle pulse when a burst ends.

Behaviour:
- Reset: CLRN low asynchronously forces Q=0, BUSY=0, DONE=0, FSM=IDLE, count=0. This holds mid-burst too; the burst is abandoned.
- S encodings:
  - 000 hold.
  - 001 shift right, Q <= {DSR, Q[W-1:1]}.
  - 010 shift left, Q <= {Q[W-2:0], DSL}.
  - 011 parallel load, Q <= D.
  - 100 rotate right.
  - 101 rotate left.
  - 110 arithmetic shift right (MSB replicated).
  - 111 synchronous clear, Q <= 0.
- Shift modes are 001, 010, 100, 101 and 110.
- DONE defaults to 0 every edge unless set as below. It self-clears even when EN=0.
- The FSM has two states: IDLE and RUN.
- IDLE, EN=1, START=0: Q updates according to S on each edge (single-step operation).
- IDLE, EN=1, START=1 (START takes priority over single-step):
  - If S is a shift mode and N>0: latch op<=S and count<=N, go to RUN, BUSY<=1, Q unchanged on this edge.
  - Otherwise (N=0 or non-shift mode): Q unchanged, stay IDLE, DONE<=1 on this edge.
- RUN, EN=1, on each edge:
  - Apply the latched op; DSL/DSR are sampled live on every shift.
  - count <= count-1.
  - If count==1 on this edge: last shift, go to IDLE, BUSY<=0, DONE<=1.
- Timing: a START accepted at edge t0 produces shifts at edges t0+1 .. t0+N. DONE is high for the cycle after edge t0+N. BUSY is high from t0 to t0+N.
- RUN, EN=0: Q, count and state frozen; BUSY stays 1.
- While in RUN, S, D, N and START are ignored. A START that arrives while BUSY is dropped, not queued.
- N > WIDTH is legal and gives repeated shifting/rotation. For example, a rotate by WIDTH returns the original value.
- No arithmetic width growth; all shifts stay within WIDTH bits.

Decomposition:
- Package univ_shift_pkg holds:
  - the mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_ASR, MODE_CLR (3 bits);
  - the state encoding ST_IDLE/ST_RUN;
  - function is_shift_mode.
- Sub-module univ_shift_step (combinational, parameter WIDTH):
  - inputs: Q, op, DSL, DSR, D; output: next Q.
  - shared by the single-step and burst paths.
- The top level holds the FSM, counter and registers.

Test Plan:
1. Reset, and single-step shift with WIDTH=8: assert CLRN low mid-operation -> Q=8'h00, BUSY=0, DONE=0 immediately, without waiting for a clock. Then S=011, D=8'hA5 -> Q=8'hA5. Then S=001, DSR=1 -> Q=8'hD2, SOR=0, SOL=1.
2. Modes: from Q=8'h96, S=110 -> 8'hCB. From Q=8'h81: S=100 -> 8'hC0; S=101 -> 8'h03. S=010 with DSL=1 on 8'h81 -> 8'h03. S=111 -> 8'h00. S=000 holds over 3 cycles.
3. Burst: Q=8'h01, START=1, S=101, N=3 at edge t0 -> BUSY=1 at t0..t0+3; Q=02, 04, 08 at t0+1..t0+3. DONE=1 only in the cycle after t0+3. A START issued during BUSY is ignored.
4. Stall: repeat scenario 3 with EN=0 for 2 cycles after t0+1 -> Q stays 8'h02 during the stall. DONE arrives 2 cycles later; final Q=8'h08.
5. Degenerate request: START with N=0 -> DONE pulses at t0, BUSY never rises, Q unchanged. START with S=011 and N=5 -> same. START with S=100 and N=8 on 8'h3C -> Q=8'h3C after 8 shifts.
6. Reset mid-burst: START with S=001, N=10; CLRN low at t0+4 -> Q=0, BUSY=0, DONE=0, no DONE pulse afterward. The next START is accepted normally.
